// File: rtl/cfg_loader.sv
// Serial configuration loader: hunts for a sync word, shifts in a 38-bit
// config frame with even parity, and commits it to the outputs atomically.
module cfg_loader #(
  parameter logic [7:0] SYNC_WORD = 8'hB2,
  parameter int         TIMEOUT   = 255
) (
  input  logic        K,
  input  logic        RST,
  input  logic        PROG,
  input  logic        DIN,
  input  logic        DVALID,
  output logic [15:0] MEM,
  output logic [1:0]  COMBOPT,
  output logic [1:0]  MUX2SEL,
  output logic [1:0]  MUX3SEL,
  output logic [1:0]  MUX4SEL,
  output logic [1:0]  MUX5SEL,
  output logic [1:0]  MUX6SEL,
  output logic [5:0]  O2M,
  output logic [1:0]  DQMUX,
  output logic        FOL,
  output logic        QINIT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CFG_VALID
);

  // state | meaning
  // IDLE  | no load in progress, DVALID ignored
  // HUNT  | sliding search for SYNC_WORD
  // DATA  | shifting 38 config bits into the shadow
  // PAR   | waiting for the parity bit, commit or fail
  typedef enum logic [1:0] {IDLE, HUNT, DATA, PAR} state_t;

  localparam int              CW          = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   IDLE_LOAD   = CW'(TIMEOUT - 1);
  localparam logic [37:0]     CFG_DEFAULT = {16'h0116, 2'b00, 2'b10, 2'b10, 2'b10,
                                             2'b00, 2'b00, 6'b000111, 2'b00, 1'b0, 1'b0};

  state_t        state, state_nxt;
  // Only seven bits are held; the live DIN completes the 8-bit window so the
  // first data bit may follow the sync word on the very next DVALID.
  logic [6:0]    sync_q;
  logic [7:0]    sync_win;
  logic [37:0]   shadow_q;
  logic [37:0]   cfg_q;
  logic [5:0]    bit_cnt;
  logic [CW-1:0] idle_cnt;
  logic          done_q, err_q, cv_q;
  logic          timeout, commit, fail, par_ok;

  assign sync_win = {sync_q, DIN};
  assign par_ok   = ~(^shadow_q ^ DIN);
  assign timeout  = (state != IDLE) && !DVALID && (idle_cnt == '0);

  always_ff @(posedge K) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    fail      = 1'b0;
    if (PROG) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT:    if (DVALID && sync_win == SYNC_WORD) state_nxt = DATA;
        DATA:    if (DVALID && bit_cnt == 6'd37)      state_nxt = PAR;
        PAR: begin
          if (DVALID) begin
            state_nxt = IDLE;
            commit    = par_ok;
            fail      = !par_ok;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (timeout) begin
        state_nxt = IDLE;
        fail      = 1'b1;
      end
    end
  end

  always_ff @(posedge K) begin
    if (RST) begin
      sync_q   <= '0;
      shadow_q <= '0;
      cfg_q    <= CFG_DEFAULT;
      bit_cnt  <= '0;
      idle_cnt <= IDLE_LOAD;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cv_q     <= 1'b0;
    end else begin
      done_q <= commit;
      if (PROG) begin
        sync_q   <= '0;
        shadow_q <= '0;
        bit_cnt  <= '0;
        idle_cnt <= IDLE_LOAD;
        err_q    <= 1'b0;
        cv_q     <= 1'b0;
      end else begin
        if (DVALID || state_nxt != state) idle_cnt <= IDLE_LOAD;
        else if (idle_cnt != '0)          idle_cnt <= idle_cnt - CW'(1);
        if (state == HUNT) begin
          bit_cnt <= '0;
          if (DVALID) sync_q <= sync_win[6:0];
        end
        if (state == DATA && DVALID) begin
          shadow_q <= {shadow_q[36:0], DIN};
          bit_cnt  <= bit_cnt + 6'd1;
        end
        if (commit) begin
          cfg_q <= shadow_q;
          cv_q  <= 1'b1;
        end
        if (fail) err_q <= 1'b1;
      end
    end
  end

  assign BUSY      = (state != IDLE);
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign CFG_VALID = cv_q;

  assign MEM     = cfg_q[37:22];
  assign COMBOPT = cfg_q[21:20];
  assign MUX2SEL = cfg_q[19:18];
  assign MUX3SEL = cfg_q[17:16];
  assign MUX4SEL = cfg_q[15:14];
  assign MUX5SEL = cfg_q[13:12];
  assign MUX6SEL = cfg_q[11:10];
  assign O2M     = cfg_q[9:4];
  assign DQMUX   = cfg_q[3:2];
  assign FOL     = cfg_q[1];
  assign QINIT   = cfg_q[0];

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter SYNC_WORD, 8'hB2: frame synchronisation pattern, MSB first.
REQ-002 Parameter TIMEOUT, 255: consecutive cycles without DVALID that abort a load in progress.
REQ-003 Port K, input, 1: clock; all state changes on the rising edge.
REQ-004 Port RST, input, 1: reset, synchronous, active-high.
REQ-005 Port PROG, input, 1: one-cycle load start or restart request.
REQ-006 Port DIN, input, 1: serial configuration bit.
REQ-007 Port DVALID, input, 1: DIN is valid this cycle.
REQ-008 Port MEM, output, 16: LUT contents for the downstream logic block.
REQ-009 Port COMBOPT, output, 2: combinational mode select.
REQ-010 Port MUX2SEL, MUX3SEL, MUX4SEL, MUX5SEL, MUX6SEL, output, 2 each: S, clock, R, X and Y source selects.
REQ-011 Port O2M, output, 6: {o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1} input steering bits.
REQ-012 Port DQMUX, output, 2: {DQmux1, DQmux2}.
REQ-013 Port FOL, output, 1: 0 = flip-flop, 1 = latch.
REQ-014 Port QINIT, output, 1: storage element initial value.
REQ-015 Port BUSY, output, 1: a load is in progress.
REQ-016 Port DONE, output, 1: one-cycle pulse on a successful commit.
REQ-017 Port ERR, output, 1: sticky load failure flag.
REQ-018 Port CFG_VALID, output, 1: outputs hold a successfully loaded configuration.

Function
REQ-019 Frame format, MSB first: SYNC_WORD, then 38 config bits, then 1 parity bit.
REQ-020 Config bit order, bit 37 down to 0: MEM[15:0], COMBOPT, MUX2SEL, MUX3SEL, MUX4SEL, MUX5SEL, MUX6SEL, O2M[5:0], DQMUX[1:0], FOL, QINIT.
REQ-021 Parity SHALL be even: the total count of ones across the 38 config bits plus the parity bit is even.
REQ-022 States: IDLE, HUNT, DATA, PAR; BUSY=1 in every state except IDLE.
REQ-023 IDLE -> HUNT on PROG; the 8-bit sync shift register clears; ERR clears; CFG_VALID clears.
REQ-024 A DIN presented with PROG in the same cycle is ignored.
REQ-025 HUNT: each DVALID shifts DIN into the sync register (sliding search).
REQ-026 HUNT -> DATA when the sync register equals SYNC_WORD; the bit counter clears to 0.
REQ-027 DATA: each DVALID shifts DIN into a 38-bit shadow register.
REQ-028 DATA -> PAR after the 38th DVALID.
REQ-029 PAR, on DVALID with correct parity: at that same edge the shadow register is copied to all config outputs, DONE=1 for exactly the next cycle, CFG_VALID=1, next state IDLE.
REQ-030 PAR, on DVALID with bad parity: ERR=1, config outputs unchanged, next state IDLE.
REQ-031 Config outputs SHALL keep their previous values throughout a load; they change only at a commit or at reset.
REQ-032 In HUNT, DATA or PAR, TIMEOUT consecutive cycles without DVALID SHALL set ERR=1 and return to IDLE.
REQ-033 The idle counter resets on every DVALID and on every state entry.
REQ-034 PROG in HUNT, DATA or PAR SHALL restart at HUNT with a discarded shadow, as in REQ-023.
REQ-035 DVALID in IDLE SHALL be ignored.
REQ-036 ERR stays set until PROG or RST.

Reset
REQ-037 On RST, state SHALL go to IDLE, counters and shadow SHALL clear, and BUSY=0, DONE=0, ERR=0, CFG_VALID=0.
REQ-038 On RST, config outputs SHALL take the default configuration: MEM=16'h0116, COMBOPT=00, MUX2SEL=MUX3SEL=MUX4SEL=10, MUX5SEL=MUX6SEL=00, O2M=6'b000111, DQMUX=00, FOL=0, QINIT=0.
REQ-039 RST asserted mid-load SHALL abort the load with no commit; RST takes priority over PROG.

Verification
REQ-040 PROG, then 8'hB2, then config with MEM=16'hFFFF and all other bits 0, then parity 0 -> MEM=FFFF and other fields 0 at the parity edge; DONE high 1 cycle; CFG_VALID=1.
REQ-041 Same frame with parity 1 -> ERR=1; outputs hold reset defaults (MEM=0116); CFG_VALID=0.
REQ-042 Garbage bits 1,0,1 before 8'hB2 -> sync still found; commit is correct.
REQ-043 DVALID gaps of 254 cycles mid-DATA -> load succeeds; a gap of 255 cycles -> ERR=1, BUSY=0.
REQ-044 PROG after 20 data bits, then a full valid frame -> only the second frame is committed; ERR=0.
REQ-045 RST asserted on the parity cycle of a valid frame -> no DONE; outputs hold defaults.
